// File: rtl/mmu_arb_pkg.sv
// Shared definitions for the PTW round-robin scheduler.
//  - FSM state encoding
//  - clog2 helper used for the port-index width
//  - default watchdog limit and counter-width helper
package mmu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int DEF_TIMEOUT = 255;

  // Index width, never narrower than one bit.
  function automatic int clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Watchdog counter width: at least 8 bits, wide enough for TIMEOUT.
  function automatic int tmo_w(input int t);
    return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
  endfunction

endpackage

// File: rtl/mmu_rr_pick.sv
// Combinational round-robin picker.
//  i_req   : request vector
//  i_last  : index of the most recently served port
//  o_grant : one-hot grant, first set bit above i_last with wrap-around
//  o_idx   : binary index of o_grant (0 when no request)
// The request vector is rotated so that port (last+1) lands on bit 0, the
// lowest set bit is isolated with x & (~x + 1), and the result is rotated back.
module mmu_rr_pick #(
  parameter int N   = 7,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx
);

  logic [IDW:0]   w_sh;
  logic [2*N-1:0] w_rot_full;
  logic [2*N-1:0] w_un;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_iso;

  // last+1 may equal N; shifting the doubled vector by N is the identity rotation.
  assign w_sh       = {1'b0, i_last} + (IDW+1)'(1);
  assign w_rot_full = {i_req, i_req} >> w_sh;
  assign w_rot      = w_rot_full[N-1:0];
  assign w_iso      = w_rot & (~w_rot + N'(1));
  assign w_un       = {w_iso, w_iso} << w_sh;
  assign o_grant    = w_un[2*N-1:N];

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++)
      if (o_grant[i]) o_idx = IDW'(i);
  end

endmodule

// File: rtl/mmu_ptw_rr_sched.sv
// Round-robin scheduler sharing one page-table walker among NUM_PORTS requesters.
// One request is accepted in IDLE, issued to the walker, the walker is held
// until its response returns, and the response is steered back to the owner.
//  clk, rstn (async, active-low)
//  i_req_valid/i_req_data/o_req_ready      : per-port request handshake
//  o_walk_valid/o_walk_data/o_walk_port    : request to the walker, i_walk_ready accepts
//  i_walk_resp_vld/_data/_err              : walker response pulse
//  o_resp_valid/o_resp_data/o_resp_err     : one-hot response, i_resp_ready per port
//  o_busy                                  : FSM not idle
// Optional build macro MMU_PTW_TIMEOUT_EN: watchdog that answers with an error
// response after TIMEOUT cycles in ISSUE/WAIT and drops any later walker reply.
module mmu_ptw_rr_sched
  import mmu_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 7,
  parameter  int REQ_WIDTH  = 88,
  parameter  int RESP_WIDTH = 64,
  parameter  int TIMEOUT    = DEF_TIMEOUT,
  localparam int IDW        = clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_PORTS-1:0]           i_req_valid,
  input  logic [NUM_PORTS*REQ_WIDTH-1:0] i_req_data,
  output logic [NUM_PORTS-1:0]           o_req_ready,
  output logic                           o_walk_valid,
  output logic [REQ_WIDTH-1:0]           o_walk_data,
  output logic [IDW-1:0]                 o_walk_port,
  input  logic                           i_walk_ready,
  input  logic                           i_walk_resp_vld,
  input  logic [RESP_WIDTH-1:0]          i_walk_resp_data,
  input  logic                           i_walk_resp_err,
  output logic [NUM_PORTS-1:0]           o_resp_valid,
  output logic [RESP_WIDTH-1:0]          o_resp_data,
  output logic                           o_resp_err,
  input  logic [NUM_PORTS-1:0]           i_resp_ready,
  output logic                           o_busy
);

  state_e                               r_state;
  logic [IDW-1:0]                       r_last;
  logic [IDW-1:0]                       r_port;
  logic [REQ_WIDTH-1:0]                 r_walk_data;
  logic                                 r_walk_valid;
  logic [NUM_PORTS-1:0]                 r_resp_valid;
  logic [RESP_WIDTH-1:0]                r_resp_data;
  logic                                 r_resp_err;

  logic [NUM_PORTS-1:0][REQ_WIDTH-1:0]  w_req_arr;
  logic [NUM_PORTS-1:0]                 w_grant;
  logic [IDW-1:0]                       w_idx;
  logic [NUM_PORTS-1:0]                 w_port_oh;

  assign w_req_arr = i_req_data;
  assign w_port_oh = NUM_PORTS'(1) << r_port;

  mmu_rr_pick #(.N(NUM_PORTS), .IDW(IDW)) u_pick (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

`ifdef MMU_PTW_TIMEOUT_EN
  localparam int TW = tmo_w(TIMEOUT);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo;
  // Fires on the TIMEOUT-th cycle spent in ISSUE/WAIT.
  assign w_tmo = (r_tmo_cnt == TW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_last       <= IDW'(NUM_PORTS - 1);
      r_port       <= '0;
      r_walk_data  <= '0;
      r_walk_valid <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
`ifdef MMU_PTW_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (|w_grant) begin
          r_walk_data  <= w_req_arr[w_idx];
          r_port       <= w_idx;
          r_walk_valid <= 1'b1;
          r_state      <= S_ISSUE;
`ifdef MMU_PTW_TIMEOUT_EN
          r_tmo_cnt    <= '0;
`endif
        end
        S_ISSUE: begin
          if (i_walk_ready) begin
            r_walk_valid <= 1'b0;
            r_state      <= S_WAIT;
          end
`ifdef MMU_PTW_TIMEOUT_EN
          else if (w_tmo) begin
            r_walk_valid <= 1'b0;
            r_resp_valid <= w_port_oh;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
`endif
        end
        S_WAIT: begin
          if (i_walk_resp_vld) begin
            r_resp_valid <= w_port_oh;
            r_resp_data  <= i_walk_resp_data;
            r_resp_err   <= i_walk_resp_err;
            r_state      <= S_RESP;
          end
`ifdef MMU_PTW_TIMEOUT_EN
          else if (w_tmo) begin
            r_resp_valid <= w_port_oh;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b1;
            r_state      <= S_RESP;
          end
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
`endif
        end
        // Only the owning port's ready completes the response.
        S_RESP: if (i_resp_ready[r_port]) begin
          r_resp_valid <= '0;
          r_last       <= r_port;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Grant is offered combinationally in IDLE only; forced low while in reset.
  assign o_req_ready  = (rstn && (r_state == S_IDLE)) ? w_grant : '0;
  assign o_walk_valid = r_walk_valid;
  assign o_walk_data  = r_walk_data;
  assign o_walk_port  = r_port;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mmu_ptw_rr_sched.sv
// Scoreboard bench for mmu_ptw_rr_sched: expected responses are queued when a
// request is driven and checked when the DUT presents them to a ready port.
module tb_mmu_ptw_rr_sched;

  localparam int NP  = 7;
  localparam int RW  = 88;
  localparam int SW  = 64;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NP-1:0]    i_req_valid;
  logic [NP*RW-1:0] i_req_data;
  logic [NP-1:0]    o_req_ready;
  logic             o_walk_valid;
  logic [RW-1:0]    o_walk_data;
  logic [IDW-1:0]   o_walk_port;
  logic             i_walk_ready;
  logic             i_walk_resp_vld;
  logic [SW-1:0]    i_walk_resp_data;
  logic             i_walk_resp_err;
  logic [NP-1:0]    o_resp_valid;
  logic [SW-1:0]    o_resp_data;
  logic             o_resp_err;
  logic [NP-1:0]    i_resp_ready;
  logic             o_busy;

  typedef struct {
    int          port;
    logic [SW-1:0] data;
    logic        err;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW-1:0] reqd[NP];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  mmu_ptw_rr_sched #(.NUM_PORTS(NP), .REQ_WIDTH(RW), .RESP_WIDTH(SW), .TIMEOUT(10)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_req_valid      (i_req_valid),
    .i_req_data       (i_req_data),
    .o_req_ready      (o_req_ready),
    .o_walk_valid     (o_walk_valid),
    .o_walk_data      (o_walk_data),
    .o_walk_port      (o_walk_port),
    .i_walk_ready     (i_walk_ready),
    .i_walk_resp_vld  (i_walk_resp_vld),
    .i_walk_resp_data (i_walk_resp_data),
    .i_walk_resp_err  (i_walk_resp_err),
    .o_resp_valid     (o_resp_valid),
    .o_resp_data      (o_resp_data),
    .o_resp_err       (o_resp_err),
    .i_resp_ready     (i_resp_ready),
    .o_busy           (o_busy)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Walker model response: fixed scramble of the request, err = request bit 0.
  function automatic logic [SW-1:0] fdat(input logic [RW-1:0] d);
    return d[SW-1:0] ^ 64'hC3C3_5A5A_0F0F_9696;
  endfunction

  task automatic set_data();
    for (int p = 0; p < NP; p++) i_req_data[p*RW +: RW] = reqd[p];
  endtask

  task automatic push_exp(input int p);
    exp_t e;
    e.port = p; e.data = fdat(reqd[p]); e.err = reqd[p][0];
    exp_q.push_back(e);
  endtask

  // Wait for port p to be offered ready, then drop its valid after the accept edge.
  task automatic wait_accept(input int p);
    bit got = 0;
    logic [NP-1:0] oh;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_req_ready[p]) begin got = 1; break; end
    end
    chk("accept_seen", got, 1);
    oh = '0; oh[p] = 1'b1;
    chk("req_ready_oh", o_req_ready, oh);
    @(posedge clk); #1;
    i_req_valid[p] = 1'b0;
  endtask

  // Act as the walker for one request expected from port ep (zero response latency).
  task automatic serve_walk(input int ep);
    bit got = 0;
    logic [RW-1:0] d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_walk_valid && i_walk_ready) begin got = 1; break; end
    end
    chk("walk_seen", got, 1);
    if (got) begin
      chk("walk_port", o_walk_port, ep);
      chk("walk_data", o_walk_data, reqd[ep]);
      d = o_walk_data;
      @(posedge clk); #1;
      i_walk_resp_vld = 1'b1; i_walk_resp_data = fdat(d); i_walk_resp_err = d[0];
      @(posedge clk); #1;
      i_walk_resp_vld = 1'b0;
    end
  endtask

  task automatic pulse_resp(input logic [SW-1:0] v);
    i_walk_resp_vld = 1'b1; i_walk_resp_data = v; i_walk_resp_err = 1'b1;
    @(posedge clk); #1;
    i_walk_resp_vld = 1'b0;
  endtask

  // Scoreboard consumer: a response is checked on the cycle it is handed over.
  initial begin
    exp_t e;
    logic [NP-1:0] oh;
    forever begin
      @(negedge clk);
      if (rstn && |(o_resp_valid & i_resp_ready)) begin
        if (exp_q.size() == 0) chk("resp_unexpected", o_resp_valid, 0);
        else begin
          e = exp_q.pop_front();
          oh = '0; oh[e.port] = 1'b1;
          chk("resp_valid", o_resp_valid, oh);
          chk("resp_data", o_resp_data, e.data);
          chk("resp_err", o_resp_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=done");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn = 1'b0;
    i_req_valid = '1; i_req_data = '0;
    i_walk_ready = 1'b1; i_walk_resp_vld = 1'b0; i_walk_resp_data = '0; i_walk_resp_err = 1'b0;
    i_resp_ready = '1;
    for (int p = 0; p < NP; p++) reqd[p] = {8'(p), 16'hBEEF, $urandom, 32'(p*3+1)};
    set_data();
    #12;
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_walk_valid", o_walk_valid, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_walk_data", o_walk_data, 0);

    // 1: all ports requesting continuously -> 0..6 then 0
    for (int k = 0; k < 8; k++) push_exp(k % NP);
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 8; k++) serve_walk(k % NP);
    i_req_valid = '0;
    repeat (2) @(posedge clk); #1;
    chk("t1_idle", o_busy, 0);

    // 2: port 3, response three cycles after acceptance, held while not ready
    reqd[3] = 88'hA5A5_A5A5_A5A5_A5A5_A5A5_A5; set_data();
    begin
      exp_t e; e.port = 3; e.data = 64'h1234; e.err = 1'b0; exp_q.push_back(e);
    end
    i_resp_ready = '0;
    i_req_valid[3] = 1'b1;
    wait_accept(3);
    chk("t2_walk_valid", o_walk_valid, 1);
    chk("t2_walk_port", o_walk_port, 3);
    chk("t2_walk_data", o_walk_data, reqd[3]);
    @(posedge clk); @(posedge clk); #1;
    i_walk_resp_vld = 1'b1; i_walk_resp_data = 64'h1234; i_walk_resp_err = 1'b0;
    @(posedge clk); #1;
    i_walk_resp_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_hold_valid", o_resp_valid, 7'b0001000);
      chk("t2_hold_data", o_resp_data, 64'h1234);
    end
    @(posedge clk); #1;
    i_resp_ready = '1;
    repeat (2) @(posedge clk); #1;

    // 3: port 6 alone, then 0 and 6 together -> 6, 0, 6
    push_exp(6); push_exp(0); push_exp(6);
    i_req_valid[6] = 1'b1;
    wait_accept(6);
    i_req_valid[6] = 1'b1; i_req_valid[0] = 1'b1;
    serve_walk(6);
    wait_accept(0);
    serve_walk(0);
    wait_accept(6);
    serve_walk(6);
    repeat (2) @(posedge clk); #1;

    // 4: stray walker responses in IDLE and ISSUE are dropped
    pulse_resp(64'hBAD0);
    chk("t4_idle_busy", o_busy, 0);
    chk("t4_idle_resp", o_resp_valid, 0);
    i_walk_ready = 1'b0;
    push_exp(1);
    i_req_valid[1] = 1'b1;
    wait_accept(1);
    pulse_resp(64'hBAD1);
    chk("t4_issue_walk", o_walk_valid, 1);
    chk("t4_issue_resp", o_resp_valid, 0);
    chk("t4_issue_busy", o_busy, 1);
    i_walk_ready = 1'b1;
    serve_walk(1);
    repeat (2) @(posedge clk); #1;

    // 5: reset while waiting on port 2's walk
    i_req_valid[2] = 1'b1;
    wait_accept(2);
    @(posedge clk); #1;
    chk("t5_wait_busy", o_busy, 1);
    chk("t5_wait_walk", o_walk_valid, 0);
    i_req_valid = '1;
    rstn = 1'b0; #1;
    chk("t5_rst_req_ready", o_req_ready, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_resp", o_resp_valid, 0);
    chk("t5_rst_port", o_walk_port, 0);
    i_req_valid = '0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    pulse_resp(64'hDEAD);
    chk("t5_stale_resp", o_resp_valid, 0);
    chk("t5_stale_busy", o_busy, 0);
    push_exp(0); push_exp(2);
    i_req_valid[0] = 1'b1; i_req_valid[2] = 1'b1;
    wait_accept(0);
    serve_walk(0);
    wait_accept(2);
    serve_walk(2);
    repeat (2) @(posedge clk); #1;

`ifdef MMU_PTW_TIMEOUT_EN
    // 6: walker never accepts -> error response within 11 cycles, late reply dropped
    begin
      exp_t e; int k; bit got;
      e.port = 4; e.data = '0; e.err = 1'b1; exp_q.push_back(e);
      got = 0; k = 0;
      i_walk_ready = 1'b0;
      i_req_valid[4] = 1'b1;
      wait_accept(4);
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (o_resp_valid != 0) begin got = 1; k = c; break; end
      end
      chk("t6_tmo_seen", got, 1);
      chk("t6_tmo_in_time", (k <= 11), 1);
      chk("t6_tmo_walk", o_walk_valid, 0);
      repeat (5) @(posedge clk); #1;
      pulse_resp(64'h5555);
      chk("t6_late_resp", o_resp_valid, 0);
      chk("t6_late_busy", o_busy, 0);
      i_walk_ready = 1'b1;
    end
`endif

    repeat (3) @(posedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
